dds_sweep_ctrl: RTL and testbench

Sweep scheduler for the DDS tone generator. It accepts a sweep configuration over a valid/ready handshake and drives the generator's tuning word `M`, amplitude `a`, start phase `Start` and `reset`. It steps `M` from a start word to a stop word at a programmable dwell, in single, repeat or triangle mode. It sits between the control/config logic and one DDS instance, and sequences that instance's inputs on DDS sample boundaries.

---
 rtl/dds_sweep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Sweep scheduler for one DDS tone generator.
// Steps the tuning word between two endpoints at a programmable dwell.
module dds_sweep_ctrl #(
  parameter int TICK_DIV = 128,
  parameter int DWELL_W  = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_m_start,
  input  logic [31:0]        cfg_m_stop,
  input  logic [31:0]        cfg_m_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [16:0]        cfg_amp,
  input  logic [31:0]        cfg_phase,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        M,
  output logic [16:0]        a,
  output logic [16:0]        b,
  output logic [31:0]        Start,
  output logic               dds_reset,
  output logic               busy,
  output logic               done,
  output logic               sweep_tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [16:0] AMP_MAX = 17'd60000;

  typedef enum logic [2:0] {
    IDLE, LOAD, SWEEP, HOLD, DONE
  } state_t;

  state_t state;
  logic loaded;
  logic [31:0] s_start, s_stop, s_step, s_phase;
  logic [16:0] s_amp;
  logic [DWELL_W-1:0] s_dwell;
  logic [1:0] s_mode;
  logic up, toward;
  logic [TW-1:0] tick;
  logic [DWELL_W-1:0] dcnt;

  logic [31:0] tgt, nxt;
  logic [32:0] sum, lim;
  logic move_up, hit, wrap, dwell_end;
  logic single, rpt;

  assign b = '0;
  assign single = (s_mode == 2'd0) || (s_mode == 2'd3);
  assign rpt = (s_mode == 2'd1);

  // Next tuning word toward the current endpoint, saturated there
  always_comb begin
    tgt = toward ? s_stop : s_start;
    move_up = toward ? up : !up;
    sum = {1'b0, M} + {1'b0, s_step};
    lim = {1'b0, tgt} + {1'b0, s_step};
    if (move_up) begin
      hit = (sum >= {1'b0, tgt});
      nxt = hit ? tgt : sum[31:0];
    end else begin
      hit = ({1'b0, M} <= lim);
      nxt = hit ? tgt : (M - s_step);
    end
    wrap = (tick == TW'(TICK_DIV - 1));
    dwell_end = wrap && (dcnt == (s_dwell - DWELL_W'(1)));
  end

  // Sweep FSM with registered DDS-side outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      loaded <= 1'b0;
      s_start <= '0;
      s_stop <= '0;
      s_step <= '0;
      s_phase <= '0;
      s_amp <= '0;
      s_dwell <= '0;
      s_mode <= '0;
      up <= 1'b0;
      toward <= 1'b0;
      tick <= '0;
      dcnt <= '0;
      cfg_ready <= 1'b0;
      M <= '0;
      a <= '0;
      Start <= '0;
      dds_reset <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sweep_tick <= 1'b0;
    end else begin
      done <= 1'b0;
      sweep_tick <= 1'b0;
      if (abort) begin
        state <= IDLE;
        a <= '0;
        busy <= 1'b0;
        dds_reset <= 1'b0;
        cfg_ready <= 1'b1;
        tick <= '0;
        dcnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_valid && cfg_ready) begin
              s_start <= cfg_m_start;
              s_stop <= cfg_m_stop;
              s_step <= cfg_m_step;
              s_phase <= cfg_phase;
              s_amp <= (cfg_amp > AMP_MAX) ? AMP_MAX : cfg_amp;
              s_dwell <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
              s_mode <= cfg_mode;
              loaded <= 1'b1;
            end
            if (start && loaded) begin
              state <= LOAD;
              busy <= 1'b1;
              cfg_ready <= 1'b0;
            end else begin
              cfg_ready <= 1'b1;
            end
          end
          LOAD: begin
            M <= s_start;
            a <= s_amp;
            Start <= s_phase;
            dds_reset <= 1'b1;
            up <= (s_stop >= s_start);
            toward <= 1'b1;
            tick <= '0;
            dcnt <= '0;
            state <= SWEEP;
          end
          SWEEP: begin
            if (dds_reset) begin
              dds_reset <= 1'b0;
            end else begin
              tick <= wrap ? '0 : tick + 1'b1;
              if (wrap) dcnt <= dwell_end ? '0 : dcnt + 1'b1;
              if (dwell_end) begin
                sweep_tick <= 1'b1;
                if (s_step != '0) begin
                  if (!toward && rpt) begin
                    M <= s_start;
                    toward <= 1'b1;
                  end else begin
                    M <= nxt;
                    if (hit) begin
                      if (single) state <= HOLD;
                      else toward <= !toward;
                    end
                  end
                end
              end
            end
          end
          HOLD: begin
            tick <= wrap ? '0 : tick + 1'b1;
            if (wrap) dcnt <= dwell_end ? '0 : dcnt + 1'b1;
            if (dwell_end) begin
              state <= DONE;
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          DONE: begin
            state <= IDLE;
            cfg_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: cycle-index model plus directed sweeps.
// Model derives M from step index arithmetic, not from counters.
module tb_dds_sweep_ctrl;
  localparam int T = 4;

  logic CLK = 0, reset = 0;
  logic cfg_valid = 0, start = 0, abort = 0;
  logic [31:0] cfg_m_start = 0, cfg_m_stop = 0, cfg_m_step = 0, cfg_phase = 0;
  logic [15:0] cfg_dwell = 0;
  logic [16:0] cfg_amp = 0;
  logic [1:0] cfg_mode = 0;
  logic cfg_ready, dds_reset, busy, done, sweep_tick;
  logic [31:0] M, Start;
  logic [16:0] a, b;

  dds_sweep_ctrl #(.TICK_DIV(T), .DWELL_W(16)) dut (
    .CLK(CLK), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m_start(cfg_m_start), .cfg_m_stop(cfg_m_stop),
    .cfg_m_step(cfg_m_step), .cfg_dwell(cfg_dwell),
    .cfg_amp(cfg_amp), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .start(start), .abort(abort),
    .M(M), .a(a), .b(b), .Start(Start),
    .dds_reset(dds_reset), .busy(busy), .done(done),
    .sweep_tick(sweep_tick)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;
  int rst_cnt = 0, done_cnt = 0;
  logic [31:0] tq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] e_M = 0, e_Start = 0;
  logic [16:0] e_a = 0;
  logic e_rst = 0, e_busy = 0, e_done = 0, e_tick = 0, e_rdy = 0;
  bit run = 0, in_done = 0, loaded = 0;
  longint k = 0;
  longint s_st, s_sp, s_stp, s_ph, s_am, s_dw, per = T, lcnt;
  int s_md;

  function automatic longint lin(longint f, longint t, longint i);
    longint v;
    if (t >= f) begin
      v = f + i * s_stp;
      if (v > t) v = t;
    end else begin
      v = f - i * s_stp;
      if (v < t) v = t;
    end
    return v;
  endfunction

  function automatic longint m_at(longint j);
    longint i;
    if (s_stp == 0) return s_st;
    if (s_md == 1) return lin(s_st, s_sp, j % (lcnt + 1));
    if (s_md == 2) begin
      i = j % (2 * lcnt);
      if (i <= lcnt) return lin(s_st, s_sp, i);
      return lin(s_sp, s_st, i - lcnt);
    end
    return lin(s_st, s_sp, j);
  endfunction

  always @(posedge CLK or negedge reset) begin : model
    bit go;
    longint j, diff;
    if (!reset) begin
      e_M = 0; e_a = 0; e_Start = 0; e_rst = 0; e_busy = 0;
      e_done = 0; e_tick = 0; e_rdy = 0;
      run = 0; in_done = 0; loaded = 0;
    end else begin
      e_tick = 0;
      e_done = 0;
      if (abort) begin
        run = 0; in_done = 0; e_a = 0; e_busy = 0; e_rst = 0; e_rdy = 1;
      end else if (in_done) begin
        in_done = 0; e_rdy = 1;
      end else if (!run) begin
        go = start && loaded;
        if (cfg_valid && e_rdy) begin
          s_st = cfg_m_start; s_sp = cfg_m_stop; s_stp = cfg_m_step;
          s_ph = cfg_phase; s_md = cfg_mode;
          s_am = (cfg_amp > 60000) ? 60000 : cfg_amp;
          s_dw = (cfg_dwell == 0) ? 1 : cfg_dwell;
          per = s_dw * T;
          diff = (s_sp >= s_st) ? s_sp - s_st : s_st - s_sp;
          lcnt = (s_stp == 0) ? 0 : (diff + s_stp - 1) / s_stp;
          if (s_stp != 0 && lcnt == 0) lcnt = 1;
          loaded = 1;
        end
        if (go) begin
          run = 1; k = 0; e_busy = 1; e_rdy = 0;
        end else e_rdy = 1;
      end else begin
        k++;
        if (k == 1) begin
          e_M = s_st; e_a = s_am; e_Start = s_ph; e_rst = 1;
        end else begin
          e_rst = 0;
          if (k >= 2 + per && (k - 2) % per == 0) begin
            j = (k - 2) / per;
            if ((s_md == 0 || s_md == 3) && s_stp != 0 && j > lcnt) begin
              e_done = 1; e_busy = 0; run = 0; in_done = 1;
            end else begin
              e_M = m_at(j); e_tick = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("M", M, e_M);
      chk("a", a, e_a);
      chk("b", b, 0);
      chk("Start", Start, e_Start);
      chk("dds_reset", dds_reset, e_rst);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("sweep_tick", sweep_tick, e_tick);
      chk("cfg_ready", cfg_ready, e_rdy);
      if (sweep_tick) tq.push_back(M);
      if (dds_reset) rst_cnt++;
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] e,
                     input logic [31:0] st, input logic [15:0] dw,
                     input logic [16:0] am, input logic [31:0] ph,
                     input logic [1:0] md);
    bit ok;
    cfg_m_start = s; cfg_m_stop = e; cfg_m_step = st; cfg_dwell = dw;
    cfg_amp = am; cfg_phase = ph; cfg_mode = md;
    cfg_valid = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready) begin ok = 1; break; end
      @(negedge CLK);
    end
    if (!ok) chk("cfg_ready_timeout", 0, 1);
    @(negedge CLK);
    cfg_valid = 0;
  endtask

  task automatic go();
    tq.delete(); rst_cnt = 0; done_cnt = 0;
    start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (done) begin seen = 1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic stop_run();
    abort = 1;
    cyc(1);
    abort = 0;
  endtask

  initial begin
    #1;
    chk("rst_M", M, 0);
    chk("rst_a", a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    #20;
    @(negedge CLK);
    reset = 1;
    chk_en = 1;
    cyc(2);
    chk("idle_ready", cfg_ready, 1);

    // start without configuration is ignored
    start = 1; cyc(1); start = 0; cyc(3);
    chk("no_cfg_start", busy, 0);

    // config + start in same cycle: start ignored
    cfg_m_start = 100; cfg_m_stop = 130; cfg_m_step = 10; cfg_dwell = 2;
    cfg_amp = 1000; cfg_phase = 0; cfg_mode = 0;
    cfg_valid = 1; start = 1; cyc(1); cfg_valid = 0; start = 0; cyc(2);
    chk("cfg_start_same", busy, 0);

    // single up sweep
    go(); wait_done(100);
    chk("single_ticks", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("single_t0", tq[0], 110);
      chk("single_t1", tq[1], 120);
      chk("single_t2", tq[2], 130);
    end
    chk("single_M_end", M, 130);
    cyc(3);
    chk("single_done_cnt", done_cnt, 1);

    // saturation, mode 3 acts as single
    cfg(100, 125, 10, 1, 1000, 0, 3);
    go(); wait_done(100);
    chk("sat_ticks", tq.size(), 3);
    if (tq.size() == 3) chk("sat_last", tq[2], 125);
    cyc(2);

    // top-of-range saturation, no wrap
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 1000, 0, 0);
    go(); wait_done(100);
    chk("top_M", M, 32'hFFFF_FFFF);
    chk("top_ticks", tq.size(), 1);
    cyc(2);

    // descending single
    cfg(50, 20, 20, 1, 1000, 0, 0);
    go(); wait_done(100);
    chk("down_M", M, 20);
    cyc(2);

    // triangle with amp clamp and phase
    cfg(10, 30, 10, 1, 70000, 32'h400, 2);
    go(); cyc(3);
    chk("clamp_a", a, 60000);
    chk("phase", Start, 32'h400);
    cyc(40);
    chk("tri_rst_pulses", rst_cnt, 1);
    if (tq.size() >= 6) begin
      chk("tri_0", tq[0], 20); chk("tri_1", tq[1], 30);
      chk("tri_2", tq[2], 20); chk("tri_3", tq[3], 10);
      chk("tri_4", tq[4], 20); chk("tri_5", tq[5], 30);
    end else chk("tri_ticks", tq.size(), 6);
    chk("tri_busy", busy, 1);
    start = 1; cyc(1); start = 0; cyc(5);
    stop_run();
    chk("abort_a", a, 0);
    chk("abort_busy", busy, 0);
    cyc(2);
    chk("abort_no_done", done_cnt, 0);

    // repeat mode
    cfg(10, 30, 10, 1, 500, 0, 1);
    go(); cyc(40);
    if (tq.size() >= 5) begin
      chk("rep_0", tq[0], 20); chk("rep_1", tq[1], 30);
      chk("rep_2", tq[2], 10); chk("rep_3", tq[3], 20);
      chk("rep_4", tq[4], 30);
    end else chk("rep_ticks", tq.size(), 5);
    chk("rep_rst_pulses", rst_cnt, 1);
    stop_run(); cyc(2);

    // step 0 with dwell 0: CW tone, ticks keep coming
    cfg(77, 200, 0, 0, 500, 0, 0);
    go(); cyc(30);
    chk("cw_M", M, 77);
    chk("cw_ticks", tq.size() >= 5, 1);
    chk("cw_busy", busy, 1);
    stop_run(); cyc(2);

    // start and abort together in IDLE
    start = 1; abort = 1; cyc(1); start = 0; abort = 0; cyc(1);
    chk("start_abort", busy, 0);

    // asynchronous reset mid-sweep
    go(); cyc(12);
    @(posedge CLK); #2;
    reset = 0;
    #1;
    chk("arst_M", M, 0);
    chk("arst_a", a, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", Start, 0);
    @(negedge CLK);
    reset = 1;
    cyc(2);
    start = 1; cyc(1); start = 0; cyc(4);
    chk("arst_no_load", busy, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
